// File: rtl/word_select_annuller_pkg.sv
// Shared helpers for the word-select annul stage and the downstream OR-reducer:
// index-width calculation and the word-packing slice macro.
`ifndef WORD_SELECT_ANNULLER_PKG_SV
`define WORD_SELECT_ANNULLER_PKG_SV

// Word i of a packed vector of w-bit words.
`define WSA_WORD(vec, i, w) vec[(w)*(i) +: (w)]

package word_select_annuller_pkg;

    // Ceiling log2, never below 1 so a single-slot index still has a bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return (result < 32'sd1) ? 32'sd1 : result;
    endfunction

    // Bit position of word `index` in a packed vector of `width`-bit words.
    function automatic int word_lsb(input int index, input int width);
        return index * width;
    endfunction

endpackage

`endif

// File: rtl/word_pipeline_delay.sv
// Width x depth shift register with synchronous clear; carries one beat per
// cycle unchanged from the first stage to the last.
module word_pipeline_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Next-stage values: new beat into stage 0, everything else moves one slot.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Stage registers; clear flushes every in-flight beat.
    always_ff @(posedge clock) begin
        if (clear) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_data = stage_q[DEPTH-1];

endmodule

// File: rtl/word_select_annuller.sv
// Address-decode and annul stage: keeps only the addressed candidate word so the
// downstream OR-reduction yields it, flags the hit and counts valid misses.
module word_select_annuller
    import word_select_annuller_pkg::*;
#(
    parameter int WORD_WIDTH  = 36,
    parameter int WORD_COUNT  = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int ADDR_BASE   = 0,
    parameter int PIPE_DEPTH  = 1,
    parameter int COUNT_WIDTH = 8,
    parameter int INDEX_WIDTH = clog2_min1(WORD_COUNT)
) (
    input  logic                           clock,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic                           in_annul,
    input  logic [ADDR_WIDTH-1:0]          in_addr,
    input  logic [WORD_WIDTH*WORD_COUNT-1:0] in_words,
    output logic                           out_valid,
    output logic [WORD_WIDTH*WORD_COUNT-1:0] out_words,
    output logic                           out_hit,
    output logic [INDEX_WIDTH-1:0]         out_hit_index,
    output logic [COUNT_WIDTH-1:0]         miss_count
);

    localparam int VEC_W     = WORD_WIDTH * WORD_COUNT;
    localparam int PAYLOAD_W = VEC_W + INDEX_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0]  BASE_EXT  = (ADDR_WIDTH+1)'(ADDR_BASE);
    localparam logic [ADDR_WIDTH:0]  COUNT_EXT = (ADDR_WIDTH+1)'(WORD_COUNT);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    if (WORD_COUNT < 1) begin : g_bad_word_count
        $error("word_select_annuller: WORD_COUNT must be at least 1");
    end
    if (PIPE_DEPTH < 1) begin : g_bad_pipe_depth
        $error("word_select_annuller: PIPE_DEPTH must be at least 1");
    end
    if ((longint'(ADDR_BASE) + longint'(WORD_COUNT)) > (64'sd1 <<< ADDR_WIDTH)) begin : g_bad_range
        $error("word_select_annuller: slot range exceeds the address space");
    end
    if (INDEX_WIDTH < clog2_min1(WORD_COUNT)) begin : g_bad_index
        $error("word_select_annuller: INDEX_WIDTH too narrow for WORD_COUNT");
    end

    logic [ADDR_WIDTH:0]      offset_s;
    logic                     hit_s;
    logic [WORD_COUNT-1:0]    select_s;
    logic [INDEX_WIDTH-1:0]   index_s;
    logic [VEC_W-1:0]         words_s;
    logic                     miss_s;
    logic [PAYLOAD_W-1:0]     payload_s;
    logic [PAYLOAD_W-1:0]     pipe_out_s;
    logic [COUNT_WIDTH-1:0]   miss_count_d;
    logic [COUNT_WIDTH-1:0]   miss_count_q;

    // Decode: the extra offset bit is the borrow, so addresses below the base never hit.
    always_comb begin
        offset_s = {1'b0, in_addr} - BASE_EXT;
        hit_s    = in_valid & ~in_annul & ~offset_s[ADDR_WIDTH] & (offset_s < COUNT_EXT);
        select_s = {WORD_COUNT{1'b0}};
        for (int i = 0; i < WORD_COUNT; i++) begin
            if (hit_s && (offset_s == (ADDR_WIDTH+1)'(i))) begin
                select_s[i] = 1'b1;
            end else begin
                select_s[i] = 1'b0;
            end
        end
    end

    // Annul every unselected word and encode the selected slot.
    always_comb begin
        words_s = {VEC_W{1'b0}};
        index_s = {INDEX_WIDTH{1'b0}};
        for (int i = 0; i < WORD_COUNT; i++) begin
            if (select_s[i]) begin
                `WSA_WORD(words_s, i, WORD_WIDTH) = `WSA_WORD(in_words, i, WORD_WIDTH);
                index_s = INDEX_WIDTH'(i);
            end else begin
                `WSA_WORD(words_s, i, WORD_WIDTH) = {WORD_WIDTH{1'b0}};
            end
        end
        payload_s = {in_valid, hit_s, index_s, words_s};
    end

    word_pipeline_delay #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (PIPE_DEPTH)
    ) u_delay (
        .clock    (clock),
        .clear    (clear),
        .in_data  (payload_s),
        .out_data (pipe_out_s)
    );

    assign out_valid     = pipe_out_s[PAYLOAD_W-1];
    assign out_hit       = pipe_out_s[PAYLOAD_W-2];
    assign out_hit_index = pipe_out_s[VEC_W +: INDEX_WIDTH];
    assign out_words     = pipe_out_s[VEC_W-1:0];

    // Miss counter next value: saturates at all-ones instead of wrapping.
    always_comb begin
        miss_s = in_valid & ~in_annul & ~hit_s;
        if (miss_s && (miss_count_q != COUNT_MAX)) begin
            miss_count_d = miss_count_q + COUNT_WIDTH'(1);
        end else begin
            miss_count_d = miss_count_q;
        end
    end

    // Miss counter register; a beat arriving with clear is never counted.
    always_ff @(posedge clock) begin
        if (clear) begin
            miss_count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            miss_count_q <= miss_count_d;
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_word_select_annuller.sv
// Randomised self-checking bench for word_select_annuller against a per-beat
// history model: each output is looked up from the beat captured PIPE_DEPTH-1 edges back.
module tb_word_select_annuller;

    localparam int WW   = 8;
    localparam int WC   = 4;
    localparam int AW   = 4;
    localparam int AB   = 6;
    localparam int PD   = 2;
    localparam int CW   = 3;
    localparam int IW   = 2;
    localparam int MAXE = 2048;
    localparam logic [31:0] WORDS = 32'hD4C3B2A1;

    logic          clock = 1'b0;
    logic          clear;
    logic          in_valid;
    logic          in_annul;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_words;
    logic          out_valid;
    logic [31:0]   out_words;
    logic          out_hit;
    logic [IW-1:0] out_hit_index;
    logic [CW-1:0] miss_count;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int miss_model = 0;

    bit          clr_h [MAXE];
    bit          vld_h [MAXE];
    bit          hit_h [MAXE];
    int          idx_h [MAXE];
    logic [31:0] vec_h [MAXE];
    logic [7:0]  sel_h [MAXE];

    word_select_annuller #(
        .WORD_WIDTH  (WW),
        .WORD_COUNT  (WC),
        .ADDR_WIDTH  (AW),
        .ADDR_BASE   (AB),
        .PIPE_DEPTH  (PD),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_annul      (in_annul),
        .in_addr       (in_addr),
        .in_words      (in_words),
        .out_valid     (out_valid),
        .out_words     (out_words),
        .out_hit       (out_hit),
        .out_hit_index (out_hit_index),
        .miss_count    (miss_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, got, exp);
        end
    endtask

    // Present one beat, let it be captured, then compare all outputs at the falling edge.
    task automatic beat(input bit v, input bit an, input int a, input logic [31:0] w, input bit c);
        int          off;
        bit          h;
        int          k;
        bit          live;
        bit          ev;
        bit          eh;
        int          ei;
        logic [31:0] evec;
        logic [7:0]  esel;
        logic [7:0]  ored;
        clear    = c;
        in_valid = v;
        in_annul = an;
        in_addr  = AW'(a);
        in_words = w;
        @(posedge clock);
        edge_n++;
        off = a - AB;
        h   = v && !an && (a >= AB) && (off < WC);
        clr_h[edge_n] = c;
        vld_h[edge_n] = v;
        hit_h[edge_n] = h;
        idx_h[edge_n] = h ? off : 0;
        vec_h[edge_n] = h ? (w & (32'hFF << (8 * off))) : 32'h0;
        sel_h[edge_n] = h ? 8'((w >> (8 * off)) & 32'hFF) : 8'h00;
        if (c) begin
            miss_model = 0;
        end else if (v && !an && !h) begin
            miss_model = (miss_model < 7) ? miss_model + 1 : 7;
        end
        @(negedge clock);
        k    = edge_n - PD + 1;
        live = (k >= 1);
        for (int j = k; j <= edge_n; j++) begin
            if (j >= 1 && clr_h[j]) live = 1'b0;
        end
        ev = live ? vld_h[k] : 1'b0;
        eh = live ? hit_h[k] : 1'b0;
        ei = live ? idx_h[k] : 0;
        evec = live ? vec_h[k] : 32'h0;
        esel = live ? sel_h[k] : 8'h00;
        ored = 8'h00;
        for (int i = 0; i < WC; i++) ored = ored | out_words[8*i +: 8];
        check_eq("out_valid", 64'(out_valid), 64'(ev));
        check_eq("out_hit", 64'(out_hit), 64'(eh));
        check_eq("out_hit_index", 64'(out_hit_index), 64'(ei));
        check_eq("out_words", 64'(out_words), 64'(evec));
        check_eq("or_word", 64'(ored), 64'(esel));
        check_eq("miss_count", 64'(miss_count), 64'(miss_model));
    endtask

    initial begin
        clear    = 1'b1;
        in_valid = 1'b0;
        in_annul = 1'b0;
        in_addr  = 4'd0;
        in_words = 32'h0;
        @(negedge clock);

        // Reset state
        beat(1'b0, 1'b0, 0, WORDS, 1'b1);
        beat(1'b0, 1'b0, 0, WORDS, 1'b1);
        check_eq("reset_miss", 64'(miss_count), 64'd0);

        // Hits on every slot back to back
        for (int a = 6; a <= 9; a++) beat(1'b1, 1'b0, a, WORDS, 1'b0);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);
        check_eq("last_hit_word", 64'(out_words[31:24]), 64'h0D4);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);

        // Misses just below and just above the slot range
        beat(1'b1, 1'b0, 5, WORDS, 1'b0);
        beat(1'b1, 1'b0, 10, WORDS, 1'b0);
        check_eq("two_misses", 64'(miss_count), 64'd2);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);

        // Annulled hit address, then invalid beat at a hit address
        beat(1'b1, 1'b1, 7, WORDS, 1'b0);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);
        beat(1'b0, 1'b0, 6, WORDS, 1'b0);
        beat(1'b0, 1'b1, 6, WORDS, 1'b0);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);

        // Saturation
        for (int n = 0; n < 9; n++) beat(1'b1, 1'b0, 0, WORDS, 1'b0);
        check_eq("miss_saturated", 64'(miss_count), 64'd7);

        // Clear with beats in flight, then a fresh beat
        beat(1'b1, 1'b0, 6, WORDS, 1'b0);
        beat(1'b1, 1'b0, 7, WORDS, 1'b0);
        beat(1'b1, 1'b0, 0, WORDS, 1'b1);
        check_eq("clear_miss", 64'(miss_count), 64'd0);
        beat(1'b1, 1'b0, 8, WORDS, 1'b0);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);
        check_eq("after_clear_index", 64'(out_hit_index), 64'd2);
        beat(1'b0, 1'b0, 0, WORDS, 1'b0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            beat(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 15)),
                 32'($urandom),
                 1'($urandom_range(0, 29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
